// File: rtl/max_pool_layer_if.sv
// Sample stream into the pooling stage and the pooled stream out of it.
// The slave modport is the pooling stage; the master modport is its environment.
interface max_pool_layer_if #(
    parameter int Bits        = 8,
    parameter int EngineCount = 2
);
    logic                             data_valid;
    logic [EngineCount-1:0][Bits-1:0] data;
    logic                             pool_valid;
    logic [EngineCount-1:0][Bits-1:0] pool_data;
    logic                             pool_done;

    modport slave (
        input  data_valid,
        input  data,
        output pool_valid,
        output pool_data,
        output pool_done
    );

    modport master (
        output data_valid,
        output data,
        input  pool_valid,
        input  pool_data,
        input  pool_done
    );
endinterface

// File: rtl/max_pool_layer.sv
// 2x2 stride-2 max pooling over a raster-ordered W x W stream, one lane per engine.
// Even rows park their horizontal pair maxima in a half-width row buffer.
//
// state | meaning
// IDLE  | waiting for start_i; frame size latched on start
// RUN   | counting accepted samples, pooling completed windows
// DONE  | one-cycle pool_done_o pulse, then back to IDLE
module max_pool_layer #(
    parameter int Bits          = 8,
    parameter int EngineCount   = 2,
    parameter int MaxMatrixSize = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [15:0]             cfg_size_i,
    input  logic                    assert_on_i,
    output logic                    pool_running_o,
    max_pool_layer_if.slave         bus
);
    localparam int BufDepth = MaxMatrixSize / 2;
    localparam int IdxW     = (BufDepth > 1) ? $clog2(BufDepth) : 1;

    typedef logic signed [Bits-1:0] sample_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] size_q, size_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    sample_t     pair_q  [EngineCount];
    sample_t     row_buf [BufDepth][EngineCount];
    sample_t     out_q   [EngineCount];
    sample_t     out_d   [EngineCount];
    sample_t     in_s    [EngineCount];
    logic        pool_valid_q, pool_valid_d;
    logic        frame_seen_q;
    logic        accept, last_col, last_row, size_bad;
    logic [IdxW-1:0] buf_idx;

    function automatic sample_t smax(sample_t a, sample_t b);
        return (a > b) ? a : b;
    endfunction

    assign accept   = (state_q == S_RUN) && bus.data_valid;
    assign last_col = (col_q == size_q - 16'd1);
    assign last_row = (row_q == size_q - 16'd1);
    assign size_bad = (cfg_size_i < 16'd2) || (cfg_size_i > 16'(MaxMatrixSize));
    assign buf_idx  = col_q[IdxW:1];

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    size_d  = cfg_size_i;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = size_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.data_valid) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                        if (last_row) state_d = S_DONE;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A window completes on the odd column of an odd row; for odd W the
    // trailing column/row never reach that point and are dropped.
    always_comb begin
        pool_valid_d = accept && col_q[0] && row_q[0];
        for (int e = 0; e < EngineCount; e++) begin
            in_s[e]  = sample_t'(bus.data[e]);
            out_d[e] = smax(smax(row_buf[buf_idx][e], pair_q[e]), in_s[e]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            size_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pool_valid_q <= 1'b0;
            frame_seen_q <= 1'b0;
            for (int e = 0; e < EngineCount; e++) begin
                pair_q[e] <= '0;
                out_q[e]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pool_valid_q <= pool_valid_d;
            if (state_q == S_DONE) frame_seen_q <= 1'b1;
            for (int e = 0; e < EngineCount; e++) begin
                if (accept && !col_q[0]) pair_q[e] <= in_s[e];
                if (pool_valid_d)        out_q[e]  <= out_d[e];
            end
        end
    end

    // Row buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < EngineCount; e++) begin
            if (accept && col_q[0] && !row_q[0])
                row_buf[buf_idx][e] <= smax(pair_q[e], in_s[e]);
        end
    end

    always_comb begin
        bus.pool_data = '0;
        for (int e = 0; e < EngineCount; e++) bus.pool_data[e] = out_q[e];
    end

    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_done  = (state_q == S_DONE);
    assign pool_running_o = (state_q == S_RUN);

    always @(posedge clk_i) begin
        if (rst_ni && assert_on_i) begin
            if (state_q == S_IDLE && start_i && cfg_size_i > 16'(MaxMatrixSize))
                $error("max_pool_layer: frame size %0d exceeds %0d", cfg_size_i, MaxMatrixSize);
            if (state_q == S_IDLE && frame_seen_q && bus.data_valid)
                $warning("max_pool_layer: data_valid asserted while idle");
        end
    end

    a_no_x : assert property (@(posedge clk_i) disable iff (!rst_ni || !assert_on_i)
        !$isunknown({bus.pool_valid, bus.pool_done}));
endmodule
